// File: rtl/arrow_judge.sv
`default_nettype none
// ============================================================================
// Module   : arrow_judge
// Judges button presses against the target arrow on each metronome beat,
// keeps score/combo and shifts an LFSR-fed 4-deep arrow queue.
// Revision : 1.0
// ============================================================================
module arrow_judge #(
    parameter logic [5:0] LFSR_SEED      = 6'b000001,
    parameter int         SCORE_MAX      = 9999,
    parameter int         COMBO_BONUS_AT = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        metronome_clk,
    input  logic [1:0]  state,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [4:0]  cur_arrow0,
    output logic [4:0]  cur_arrow1,
    output logic [4:0]  cur_arrow2,
    output logic [4:0]  cur_arrow3,
    output logic [13:0] score,
    output logic [13:0] comboCount,
    output logic        hit_pulse,
    output logic        miss_pulse
);

    localparam logic [1:0]  c_ST_GAME    = 2'd0;
    localparam logic [1:0]  c_ST_RESET   = 2'd2;
    localparam logic [4:0]  c_ARROW_NONE = 5'd20;
    localparam logic [13:0] c_SCORE_MAX  = 14'(SCORE_MAX);
    localparam logic [13:0] c_BONUS_AT   = 14'(COMBO_BONUS_AT);

    // bit0/bit1: two-stage synchroniser, bit2: previous synchronised level
    logic [2:0]  r_metro_sync;
    logic [3:0]  r_btn_prev;
    logic [3:0]  r_press_mask;
    logic [5:0]  r_lfsr;
    logic [4:0]  r_arrow0, r_arrow1, r_arrow2, r_arrow3;
    logic [13:0] r_score, r_combo;
    logic        r_hit, r_miss;

    logic        w_beat;
    logic [3:0]  w_btn, w_btn_rise, w_req;
    logic        w_is_hit, w_is_neutral;
    logic [5:0]  w_lfsr_next;
    logic [4:0]  w_new_arrow;
    logic [14:0] w_score_sum;
    logic [13:0] w_score_next, w_combo_next;

    function automatic logic [3:0] f_arrow_mask(input logic [4:0] code);
        case (code)
            5'd10:   f_arrow_mask = 4'b1000;
            5'd11:   f_arrow_mask = 4'b0100;
            5'd12:   f_arrow_mask = 4'b0010;
            5'd13:   f_arrow_mask = 4'b0001;
            5'd14:   f_arrow_mask = 4'b1100;
            5'd15:   f_arrow_mask = 4'b1010;
            5'd16:   f_arrow_mask = 4'b1001;
            5'd17:   f_arrow_mask = 4'b0110;
            5'd18:   f_arrow_mask = 4'b0101;
            5'd19:   f_arrow_mask = 4'b0011;
            default: f_arrow_mask = 4'b0000;
        endcase
    endfunction

    assign w_beat       = r_metro_sync[1] & ~r_metro_sync[2];
    assign w_btn        = {btn_up, btn_down, btn_left, btn_right};
    assign w_btn_rise   = w_btn & ~r_btn_prev;
    assign w_req        = f_arrow_mask(r_arrow3);
    assign w_is_neutral = (w_req == 4'b0000) && (r_press_mask == 4'b0000);
    assign w_is_hit     = (w_req != 4'b0000) && (r_press_mask == w_req);

    assign w_lfsr_next  = {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};
    assign w_new_arrow  = 5'd10 + 5'(w_lfsr_next % 6'd11);

    assign w_score_sum  = {1'b0, r_score} + ((r_combo >= c_BONUS_AT) ? 15'd2 : 15'd1);
    assign w_score_next = (w_score_sum > {1'b0, c_SCORE_MAX}) ? c_SCORE_MAX : w_score_sum[13:0];
    assign w_combo_next = (r_combo >= c_SCORE_MAX) ? c_SCORE_MAX : r_combo + 14'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_metro_sync <= 3'b000;
            r_btn_prev   <= 4'b0000;
            r_press_mask <= 4'b0000;
            r_lfsr       <= LFSR_SEED;
            r_arrow0     <= c_ARROW_NONE;
            r_arrow1     <= c_ARROW_NONE;
            r_arrow2     <= c_ARROW_NONE;
            r_arrow3     <= c_ARROW_NONE;
            r_score      <= 14'd0;
            r_combo      <= 14'd0;
            r_hit        <= 1'b0;
            r_miss       <= 1'b0;
        end else begin
            r_metro_sync <= {r_metro_sync[1:0], metronome_clk};
            r_btn_prev   <= w_btn;
            r_hit        <= 1'b0;
            r_miss       <= 1'b0;
            if (state == c_ST_RESET) begin
                r_press_mask <= 4'b0000;
                r_lfsr       <= LFSR_SEED;
                r_arrow0     <= c_ARROW_NONE;
                r_arrow1     <= c_ARROW_NONE;
                r_arrow2     <= c_ARROW_NONE;
                r_arrow3     <= c_ARROW_NONE;
                r_score      <= 14'd0;
                r_combo      <= 14'd0;
            end else if (state == c_ST_GAME) begin
                if (w_beat) begin
                    if (w_is_hit) begin
                        r_score <= w_score_next;
                        r_combo <= w_combo_next;
                        r_hit   <= 1'b1;
                    end else if (!w_is_neutral) begin
                        r_combo <= 14'd0;
                        r_miss  <= 1'b1;
                    end
                    r_lfsr       <= w_lfsr_next;
                    r_arrow3     <= r_arrow2;
                    r_arrow2     <= r_arrow1;
                    r_arrow1     <= r_arrow0;
                    r_arrow0     <= w_new_arrow;
                    // Edges in the beat cycle belong to the next window
                    r_press_mask <= w_btn_rise;
                end else begin
                    r_press_mask <= r_press_mask | w_btn_rise;
                end
            end else begin
                r_press_mask <= 4'b0000;
            end
        end
    end

    assign cur_arrow0 = r_arrow0;
    assign cur_arrow1 = r_arrow1;
    assign cur_arrow2 = r_arrow2;
    assign cur_arrow3 = r_arrow3;
    assign score      = r_score;
    assign comboCount = r_combo;
    assign hit_pulse  = r_hit;
    assign miss_pulse = r_miss;

endmodule
`default_nettype wire
